alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_pkg.sv | 53 +++++
 rtl/rr_arb2.sv | 60 ++++++
 rtl/alu_arbiter.sv | 140 ++++++++++++++
 tb/tb_alu_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared ALU control codes, arbiter state encoding and the
//                record type for an accepted operation.
//  Revision    : 1.0  initial release
// ============================================================================
package alu_pkg;

    localparam int unsigned c_DATA_W = 32;
    localparam int unsigned c_CTRL_W = 4;

    // ALUControl codes understood by the ALU
    localparam logic [3:0] c_ALU_ADD  = 4'b0000;
    localparam logic [3:0] c_ALU_SUB  = 4'b1000;
    localparam logic [3:0] c_ALU_SLL  = 4'b0001;
    localparam logic [3:0] c_ALU_SLT  = 4'b0010;
    localparam logic [3:0] c_ALU_SLTU = 4'b0011;
    localparam logic [3:0] c_ALU_XOR  = 4'b0100;
    localparam logic [3:0] c_ALU_SRL  = 4'b0101;
    localparam logic [3:0] c_ALU_SRA  = 4'b1101;
    localparam logic [3:0] c_ALU_OR   = 4'b0110;
    localparam logic [3:0] c_ALU_AND  = 4'b0111;

    // Arbiter sequencing: IDLE and RESP may accept, ISSUE never does
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_RESP  = 2'b10
    } arb_state_t;

    // Everything the arbiter keeps about an accepted operation
    typedef struct packed {
        logic        id;
        logic        illegal;
        logic [3:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
    } op_latch_t;

    // True for the ten codes the ALU implements
    function automatic logic is_legal_op(input logic [3:0] op);
        logic legal;
        case (op)
            c_ALU_ADD, c_ALU_SUB, c_ALU_SLL, c_ALU_SLT, c_ALU_SLTU,
            c_ALU_XOR, c_ALU_SRL, c_ALU_SRA, c_ALU_OR,  c_ALU_AND: legal = 1'b1;
            default:                                               legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage : alu_pkg
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb2
//  Description : Two-way round-robin arbiter. Grants at most one valid
//                requester while enabled; under contention the requester not
//                granted last wins. The pointer advances on every grant.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_en,
    input  logic [1:0] i_valid,
    output logic [1:0] o_grant,
    output logic       o_grant_id
);

    // Index of the requester granted most recently
    logic r_last;
    logic w_pick1;

    // Choose the winner: a lone requester always wins, contention alternates
    always_comb begin
        w_pick1 = 1'b0;
        o_grant = 2'b00;
        if (i_en) begin
            case (i_valid)
                2'b01: begin
                    w_pick1 = 1'b0;
                    o_grant = 2'b01;
                end
                2'b10: begin
                    w_pick1 = 1'b1;
                    o_grant = 2'b10;
                end
                2'b11: begin
                    w_pick1 = ~r_last;
                    o_grant = r_last ? 2'b01 : 2'b10;
                end
                default: begin
                    w_pick1 = 1'b0;
                    o_grant = 2'b00;
                end
            endcase
        end
    end

    assign o_grant_id = w_pick1;

    // Remember who won; reset to 1 so requester 0 wins the first contention
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last <= 1'b1;
        end else if (i_en && (i_valid != 2'b00)) begin
            r_last <= w_pick1;
        end
    end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_arbiter
//  Description : Shares one registered ALU between two requesters. An
//                accepted operation is issued to the ALU for one cycle and
//                answered in the following cycle (handshake -> response in
//                two edges). A new request may be accepted in the response
//                cycle, giving one operation every two cycles. Undefined
//                codes run as ADD but are answered with illegal=1, result 0.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_arbiter
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    // requester 0
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [3:0]  req0_op,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    // requester 1
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [3:0]  req1_op,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    // response
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [31:0] rsp_result,
    output logic        rsp_zero,
    output logic        rsp_illegal,
    // ALU side
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_ctrl,
    input  logic [31:0] alu_result
);

    arb_state_t  r_state;
    arb_state_t  w_state_nxt;
    op_latch_t   r_lat;
    op_latch_t   w_sel;

    logic        w_accept;
    logic [1:0]  w_grant;
    logic        w_grant_id;
    logic        w_handshake;
    logic        w_in_resp;
    logic [3:0]  w_sel_op;
    logic [31:0] w_rsp_result;

    assign w_accept = (r_state == ST_IDLE) || (r_state == ST_RESP);

    rr_arb2 u_rr_arb2 (
        .clk        (clk),
        .reset      (reset),
        .i_en       (w_accept),
        .i_valid    ({req1_valid, req0_valid}),
        .o_grant    (w_grant),
        .o_grant_id (w_grant_id)
    );

    assign req0_ready  = w_grant[0];
    assign req1_ready  = w_grant[1];
    // The arbiter only grants valid requesters, so any grant is a handshake
    assign w_handshake = |w_grant;

    // Build the record for the winning requester; illegal codes run as ADD
    always_comb begin
        w_sel_op      = w_grant_id ? req1_op : req0_op;
        w_sel.id      = w_grant_id;
        w_sel.illegal = ~is_legal_op(w_sel_op);
        w_sel.ctrl    = is_legal_op(w_sel_op) ? w_sel_op : c_ALU_ADD;
        w_sel.a       = w_grant_id ? req1_a : req0_a;
        w_sel.b       = w_grant_id ? req1_b : req0_b;
    end

    // State register; reset drops any in-flight operation
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state sequencing and the response strobe
    always_comb begin
        w_state_nxt = r_state;
        rsp_valid   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_handshake) begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid   = 1'b1;
                w_state_nxt = w_handshake ? ST_ISSUE : ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Capture the accepted operation; this is the only place the ALU
    // operands change, so they hold their values outside ISSUE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lat.id      <= 1'b0;
            r_lat.illegal <= 1'b0;
            r_lat.ctrl    <= c_ALU_ADD;
            r_lat.a       <= 32'd0;
            r_lat.b       <= 32'd0;
        end else if (w_handshake) begin
            r_lat <= w_sel;
        end
    end

    assign alu_a    = r_lat.a;
    assign alu_b    = r_lat.b;
    assign alu_ctrl = r_lat.ctrl;

    // Response fields; zero is derived here rather than taken from the ALU
    assign w_in_resp    = (r_state == ST_RESP);
    assign w_rsp_result = (w_in_resp && !r_lat.illegal) ? alu_result : 32'd0;
    assign rsp_result   = w_rsp_result;
    assign rsp_zero     = w_in_resp && (w_rsp_result == 32'd0);
    assign rsp_illegal  = w_in_resp && r_lat.illegal;
    assign rsp_id       = r_lat.id;

endmodule : alu_arbiter
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_arbiter
//  Description : Self-checking bench for alu_arbiter with a registered ALU
//                model on the ALU-side ports.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_arbiter;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [3:0]  req0_op, req1_op;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        rsp_valid, rsp_id, rsp_zero, rsp_illegal;
    logic [31:0] rsp_result;
    logic [31:0] alu_a, alu_b;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_result = 32'd0;

    int n_cmp = 0;
    int n_err = 0;
    logic tb_last;   // bench's own record of the last granted requester

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_op     (req0_op),
        .req0_a      (req0_a),
        .req0_b      (req0_b),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_op     (req1_op),
        .req1_a      (req1_a),
        .req1_b      (req1_b),
        .rsp_valid   (rsp_valid),
        .rsp_id      (rsp_id),
        .rsp_result  (rsp_result),
        .rsp_zero    (rsp_zero),
        .rsp_illegal (rsp_illegal),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_ctrl    (alu_ctrl),
        .alu_result  (alu_result)
    );

    // Registered ALU stand-in: result appears one edge after operands
    always_ff @(posedge clk) begin
        case (alu_ctrl)
            c_ALU_ADD:  alu_result <= alu_a + alu_b;
            c_ALU_SUB:  alu_result <= alu_a - alu_b;
            c_ALU_SLL:  alu_result <= alu_a << alu_b[4:0];
            c_ALU_SLT:  alu_result <= ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
            c_ALU_SLTU: alu_result <= (alu_a < alu_b) ? 32'd1 : 32'd0;
            c_ALU_XOR:  alu_result <= alu_a ^ alu_b;
            c_ALU_SRL:  alu_result <= alu_a >> alu_b[4:0];
            c_ALU_SRA:  alu_result <= $unsigned($signed(alu_a) >>> alu_b[4:0]);
            c_ALU_OR:   alu_result <= alu_a | alu_b;
            c_ALU_AND:  alu_result <= alu_a & alu_b;
            default:    alu_result <= 32'hDEAD_BEEF;
        endcase
    end

    typedef struct {
        logic        id;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  exp_ctrl;
        logic [31:0] exp_res;
        logic        exp_zero;
        logic        exp_ill;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic set_req(input logic id, input logic v, input logic [3:0] op,
                           input logic [31:0] a, input logic [31:0] b);
        if (id) begin
            req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
        end else begin
            req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
        end
    endtask

    // One lone request: ready, ISSUE contents, response, then back to idle
    task automatic run_single(input vec_t v, input string tag);
        @(negedge clk);
        set_req(v.id, 1'b1, v.op, v.a, v.b);
        #1;
        chk({tag, ".ready"},       v.id ? req1_ready : req0_ready, 32'd1);
        chk({tag, ".other_ready"}, v.id ? req0_ready : req1_ready, 32'd0);
        @(posedge clk);
        #1;
        // scramble operands: the arbiter must not look at them any more
        set_req(v.id, 1'b0, 4'hE, 32'hDEAD_BEEF, 32'hCAFE_F00D);
        tb_last = v.id;
        @(negedge clk);
        chk({tag, ".issue_valid"}, rsp_valid, 32'd0);
        chk({tag, ".issue_ready"}, {req1_ready, req0_ready}, 32'd0);
        chk({tag, ".issue_ctrl"},  alu_ctrl, v.exp_ctrl);
        chk({tag, ".issue_a"},     alu_a, v.a);
        chk({tag, ".issue_b"},     alu_b, v.b);
        @(negedge clk);
        chk({tag, ".rsp_valid"},   rsp_valid, 32'd1);
        chk({tag, ".rsp_id"},      rsp_id, v.id);
        chk({tag, ".rsp_result"},  rsp_result, v.exp_res);
        chk({tag, ".rsp_zero"},    rsp_zero, v.exp_zero);
        chk({tag, ".rsp_illegal"}, rsp_illegal, v.exp_ill);
        @(negedge clk);
        chk({tag, ".after_rsp"},   rsp_valid, 32'd0);
    endtask

    initial begin
        logic       exp_g;
        logic       rid;
        int         grants, rsps, last_g_c, last_r_c;
        logic       q[$];

        vecs[0]  = '{1'b0, 4'b0000, 32'd5,         32'd7,        4'b0000, 32'd12,        1'b0, 1'b0};
        vecs[1]  = '{1'b1, 4'b1000, 32'd9,         32'd9,        4'b1000, 32'd0,         1'b1, 1'b0};
        vecs[2]  = '{1'b0, 4'b0001, 32'd1,         32'd4,        4'b0001, 32'd16,        1'b0, 1'b0};
        vecs[3]  = '{1'b1, 4'b0010, 32'hFFFF_FFFF, 32'd1,        4'b0010, 32'd1,         1'b0, 1'b0};
        vecs[4]  = '{1'b0, 4'b0011, 32'hFFFF_FFFF, 32'd1,        4'b0011, 32'd0,         1'b1, 1'b0};
        vecs[5]  = '{1'b1, 4'b0100, 32'h0000_F0F0, 32'h0000_FF00, 4'b0100, 32'h0000_0FF0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 4'b0101, 32'h8000_0000, 32'd4,        4'b0101, 32'h0800_0000, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 4'b1101, 32'h8000_0000, 32'd4,        4'b1101, 32'hF800_0000, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 4'b0110, 32'h0000_00F0, 32'h0000_000F, 4'b0110, 32'h0000_00FF, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 4'b0111, 32'h0000_00F0, 32'h0000_003C, 4'b0111, 32'h0000_0030, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 4'b1111, 32'd3,         32'd4,        4'b0000, 32'd0,         1'b1, 1'b1};
        vecs[11] = '{1'b0, 4'b1001, 32'd1,         32'd1,        4'b0000, 32'd0,         1'b1, 1'b1};

        set_req(1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
        set_req(1'b1, 1'b0, 4'h0, 32'd0, 32'd0);
        reset   = 1'b1;
        tb_last = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset.rsp_valid",   rsp_valid,   32'd0);
        chk("reset.rsp_id",      rsp_id,      32'd0);
        chk("reset.rsp_illegal", rsp_illegal, 32'd0);
        chk("reset.alu_a",       alu_a,       32'd0);
        chk("reset.alu_b",       alu_b,       32'd0);
        chk("reset.alu_ctrl",    alu_ctrl,    32'd0);

        // Contention straight out of reset; req1 is held and taken in RESP
        reset = 1'b0;
        set_req(1'b0, 1'b1, 4'b1000, 32'd9, 32'd9);
        set_req(1'b1, 1'b1, 4'b0110, 32'h0000_00F0, 32'h0000_000F);
        #1;
        chk("both.first_grant", {req1_ready, req0_ready}, 32'b01);
        @(posedge clk);
        #1;
        set_req(1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
        @(negedge clk);
        chk("both.issue_ready", {req1_ready, req0_ready}, 32'b00);
        @(negedge clk);
        chk("both.rsp0_valid",  rsp_valid,  32'd1);
        chk("both.rsp0_id",     rsp_id,     32'd0);
        chk("both.rsp0_result", rsp_result, 32'd0);
        chk("both.rsp0_zero",   rsp_zero,   32'd1);
        chk("both.resp_ready1", {req1_ready, req0_ready}, 32'b10);
        @(posedge clk);
        #1;
        set_req(1'b1, 1'b0, 4'h0, 32'd0, 32'd0);
        @(negedge clk);
        chk("both.issue2_valid", rsp_valid, 32'd0);
        @(negedge clk);
        chk("both.rsp1_valid",  rsp_valid,  32'd1);
        chk("both.rsp1_id",     rsp_id,     32'd1);
        chk("both.rsp1_result", rsp_result, 32'h0000_00FF);
        chk("both.rsp1_zero",   rsp_zero,   32'd0);
        tb_last = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_single(vecs[i], $sformatf("vec%0d", i));
        end

        // Both held valid for 8 grants: alternation and 2-cycle spacing
        exp_g    = ~tb_last;
        grants   = 0;
        rsps     = 0;
        last_g_c = -1;
        last_r_c = -1;
        @(negedge clk);
        set_req(1'b0, 1'b1, c_ALU_ADD, 32'd1, 32'd1);
        set_req(1'b1, 1'b1, c_ALU_ADD, 32'd10, 32'd10);
        for (int c = 0; c < 40 && rsps < 8; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if ((req0_ready || req1_ready) && grants < 8) begin
                chk($sformatf("rr.grant%0d", grants), {req1_ready, req0_ready},
                    exp_g ? 32'b10 : 32'b01);
                if (last_g_c >= 0) chk("rr.grant_gap", c - last_g_c, 32'd2);
                last_g_c = c;
                q.push_back(exp_g);
                tb_last = exp_g;
                exp_g   = ~exp_g;
                grants++;
            end
            if (rsp_valid) begin
                if (q.size() == 0) begin
                    chk("rr.spurious_rsp", 32'd1, 32'd0);
                end else begin
                    rid = q.pop_front();
                    chk($sformatf("rr.rsp%0d_id", rsps), rsp_id, rid);
                    chk($sformatf("rr.rsp%0d_result", rsps), rsp_result, rid ? 32'd20 : 32'd2);
                    if (last_r_c >= 0) chk("rr.rsp_gap", c - last_r_c, 32'd2);
                end
                last_r_c = c;
                rsps++;
            end
            @(posedge clk);
            #1;
            if (grants == 8) begin
                set_req(1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
                set_req(1'b1, 1'b0, 4'h0, 32'd0, 32'd0);
            end
        end
        chk("rr.grant_count", grants, 32'd8);
        chk("rr.rsp_count",   rsps,   32'd8);
        @(negedge clk);
        chk("rr.drained", rsp_valid, 32'd0);

        // Reset in the middle of ISSUE discards the operation
        @(negedge clk);
        set_req(1'b0, 1'b1, c_ALU_ADD, 32'd3, 32'd4);
        @(posedge clk);
        #1;
        set_req(1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_mid.rsp_valid",   rsp_valid,   32'd0);
        chk("rst_mid.rsp_id",      rsp_id,      32'd0);
        chk("rst_mid.rsp_illegal", rsp_illegal, 32'd0);
        chk("rst_mid.alu_a",       alu_a,       32'd0);
        chk("rst_mid.alu_b",       alu_b,       32'd0);
        chk("rst_mid.alu_ctrl",    alu_ctrl,    32'd0);
        tb_last = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("rst_mid.no_rsp%0d", k), rsp_valid, 32'd0);
        end
        run_single('{1'b1, c_ALU_AND, 32'h0000_FF00, 32'h0000_0FF0,
                     c_ALU_AND, 32'h0000_0F00, 1'b0, 1'b0}, "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_alu_arbiter
`default_nettype wire
